// File: rtl/pipe_fetch.sv
// Instruction-fetch stage and IF/ID register of the five-stage pipeline.
// Owns the PC and the imem handshake, with a one-entry skid buffer and branch delay slot.
module pipe_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic [1:0]  i_pcsource,
  input  logic [31:0] i_bpc,
  input  logic [31:0] i_rpc,
  input  logic [31:0] i_jpc,
  input  logic        i_nostall,
  output logic [31:0] o_inst,
  output logic [31:0] o_dpc4,
  output logic        o_dvalid,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_dpc4;
  logic        r_dvalid;
  logic [31:0] r_sinst;
  logic [31:0] r_spc4;
  logic        r_svalid;
  logic        r_pend;
  logic [31:0] r_ptgt;

  logic        w_req;
  logic        w_ack;
  logic        w_consume;
  logic        w_load;
  logic        w_redirect;
  logic [31:0] w_pc4;
  logic [31:0] w_target;

  // The request drops the instant reset rises so memory sees an abandoned transaction.
  assign w_req      = !r_svalid && !rst;
  assign w_ack      = w_req && i_imem_ack;
  assign w_consume  = r_dvalid && i_nostall;
  assign w_load     = !r_dvalid || w_consume;
  assign w_redirect = w_consume && (i_pcsource != 2'b00);
  assign w_pc4      = r_pc + 32'd4;

  always_comb begin
    w_target = r_pc;
    case (i_pcsource)
      2'b01:   w_target = i_bpc;
      2'b10:   w_target = i_rpc;
      2'b11:   w_target = i_jpc;
      default: w_target = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_inst   <= 32'h0;
      r_dpc4   <= 32'h0;
      r_dvalid <= 1'b0;
      r_sinst  <= 32'h0;
      r_spc4   <= 32'h0;
      r_svalid <= 1'b0;
      r_pend   <= 1'b0;
      r_ptgt   <= 32'h0;
    end else begin
      if (w_load) begin
        if (r_svalid) begin
          r_inst   <= r_sinst;
          r_dpc4   <= r_spc4;
          r_dvalid <= 1'b1;
          r_svalid <= 1'b0;
        end else if (w_ack) begin
          r_inst   <= i_imem_rdata;
          r_dpc4   <= w_pc4;
          r_dvalid <= 1'b1;
        end else begin
          r_inst   <= 32'h0;
          r_dvalid <= 1'b0;
        end
      end else if (w_ack) begin
        r_sinst  <= i_imem_rdata;
        r_spc4   <= w_pc4;
        r_svalid <= 1'b1;
      end

      // A redirect whose delay slot is already in hand wins over the sequential pc+4.
      if (w_redirect && (r_svalid || w_ack)) begin
        r_pc <= w_target;
      end else if (w_ack) begin
        r_pc <= r_pend ? r_ptgt : w_pc4;
      end

      if (w_ack) begin
        r_pend <= 1'b0;
      end
      if (w_redirect && !r_svalid && !w_ack) begin
        r_pend <= 1'b1;
        r_ptgt <= w_target;
      end
    end
  end

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_pc;
  assign o_inst      = r_inst;
  assign o_dpc4      = r_dpc4;
  assign o_dvalid    = r_dvalid;
  assign o_pc        = r_pc;

endmodule

// File: tb/tb_pipe_fetch.sv
// Randomized bench for pipe_fetch: a variable-latency memory plus a decode model
// that checks consumed instructions against architectural program order.
module tb_pipe_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [1:0]  i_pcsource;
  logic [31:0] i_bpc;
  logic [31:0] i_rpc;
  logic [31:0] i_jpc;
  logic        i_nostall;
  logic [31:0] o_inst;
  logic [31:0] o_dpc4;
  logic        o_dvalid;
  logic [31:0] o_pc;

  pipe_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .i_pcsource   (i_pcsource),
    .i_bpc        (i_bpc),
    .i_rpc        (i_rpc),
    .i_jpc        (i_jpc),
    .i_nostall    (i_nostall),
    .o_inst       (o_inst),
    .o_dpc4       (o_dpc4),
    .o_dvalid     (o_dvalid),
    .o_pc         (o_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory and decode model state.
  bit          busy;
  logic [31:0] heldAddr;
  int          lat;
  int          forceLat;
  int          nostallPct;
  int          branchPct;
  logic [31:0] expNext;
  logic [31:0] afterTgt;
  bit          inSlot;
  bit          skidFull;
  int          idle;
  bit          timedOut;
  logic [31:0] reqLog[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hDEAD_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    busy     = 1'b0;
    heldAddr = 32'h0;
    lat      = 0;
    expNext  = 32'h0000_0000;
    afterTgt = 32'h0;
    inSlot   = 1'b0;
    skidFull = 1'b0;
    idle     = 0;
    reqLog.delete();
  endtask

  function automatic logic [31:0] pickTarget();
    logic [31:0] t;
    t = $urandom;
    t[1:0] = 2'b00;
    if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 + 32'd4 * $urandom_range(0, 3);
    return t;
  endfunction

  task automatic applyStimulus();
    bit          ack;
    bit          consume;
    bit          newReq;
    logic [31:0] tgt;
    @(negedge clk);
    checkOutput("req_vs_skid", {31'd0, o_imem_req}, {31'd0, !skidFull});
    if (!o_dvalid) checkOutput("nop_when_empty", o_inst, 32'h0);

    ack          = 1'b0;
    newReq       = 1'b0;
    i_imem_rdata = $urandom;
    if (busy) begin
      checkOutput("req_held", {31'd0, o_imem_req}, 32'd1);
    end else if (o_imem_req) begin
      busy     = 1'b1;
      newReq   = 1'b1;
      heldAddr = o_imem_addr;
      reqLog.push_back(o_imem_addr);
      if (forceLat >= 0) lat = forceLat;
      else lat = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
    end
    if (busy && o_imem_req) begin
      if (!newReq) checkOutput("addr_hold", o_imem_addr, heldAddr);
      if (lat == 0) begin
        ack          = 1'b1;
        i_imem_rdata = memWord(heldAddr);
        busy         = 1'b0;
      end else begin
        lat--;
      end
    end
    i_imem_ack = ack;

    i_nostall  = ($urandom_range(0, 99) < nostallPct);
    consume    = o_dvalid && i_nostall;
    i_pcsource = 2'($urandom_range(0, 3));
    i_bpc      = $urandom;
    i_rpc      = $urandom;
    i_jpc      = $urandom;
    if (consume) begin
      idle = 0;
      checkOutput("dpc4", o_dpc4, expNext + 32'd4);
      checkOutput("inst", o_inst, memWord(expNext));
      if (!inSlot && ($urandom_range(0, 99) < branchPct)) begin
        tgt        = pickTarget();
        i_pcsource = 2'($urandom_range(1, 3));
        case (i_pcsource)
          2'b01:   i_bpc = tgt;
          2'b10:   i_rpc = tgt;
          default: i_jpc = tgt;
        endcase
        afterTgt = tgt;
        inSlot   = 1'b1;
        expNext  = expNext + 32'd4;
      end else begin
        i_pcsource = 2'b00;
        if (inSlot) begin
          inSlot  = 1'b0;
          expNext = afterTgt;
        end else begin
          expNext = expNext + 32'd4;
        end
      end
    end else begin
      idle++;
      if (idle > 40 && !timedOut) begin
        timedOut = 1'b1;
        checkOutput("progress_timeout", idle, 32'd0);
      end
    end

    // A response arriving while decode holds its instruction parks until decode moves.
    if (skidFull && (!o_dvalid || consume)) skidFull = 1'b0;
    else if (o_dvalid && !consume && ack) skidFull = 1'b1;
  endtask

  initial begin
    rst          = 1'b1;
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'h0;
    i_pcsource   = 2'b00;
    i_bpc        = 32'h0;
    i_rpc        = 32'h0;
    i_jpc        = 32'h0;
    i_nostall    = 1'b0;
    timedOut     = 1'b0;
    forceLat     = 0;
    nostallPct   = 100;
    branchPct    = 0;
    resetModel();

    repeat (2) @(negedge clk);
    checkOutput("rst_req", {31'd0, o_imem_req}, 32'd0);
    checkOutput("rst_pc", o_pc, 32'h0);
    checkOutput("rst_inst", o_inst, 32'h0);
    checkOutput("rst_dpc4", o_dpc4, 32'h0);
    checkOutput("rst_dvalid", {31'd0, o_dvalid}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero-wait streaming: back-to-back sequential fetches.
    repeat (4) applyStimulus();
    if (reqLog.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkOutput("seq_addr", reqLog[i], 32'd4 * i);
    end else begin
      checkOutput("seq_count", reqLog.size(), 32'd4);
    end

    // Slow memory for a few requests, then randomized traffic.
    forceLat = 3;
    repeat (10) applyStimulus();
    forceLat   = -1;
    nostallPct = 70;
    branchPct  = 25;
    for (int i = 0; i < 2500 && !timedOut; i++) applyStimulus();

    // Reset while a slow request is outstanding.
    forceLat   = 3;
    nostallPct = 100;
    branchPct  = 0;
    for (int i = 0; i < 10 && !busy; i++) applyStimulus();
    #2 rst = 1'b1;
    #1;
    checkOutput("async_req", {31'd0, o_imem_req}, 32'd0);
    checkOutput("async_pc", o_pc, 32'h0);
    checkOutput("async_inst", o_inst, 32'h0);
    checkOutput("async_dpc4", o_dpc4, 32'h0);
    checkOutput("async_dvalid", {31'd0, o_dvalid}, 32'd0);
    resetModel();
    i_imem_ack = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    forceLat = 0;
    repeat (4) applyStimulus();
    if (reqLog.size() > 0) checkOutput("post_rst_addr", reqLog[0], 32'h0);
    else checkOutput("post_rst_count", reqLog.size(), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_fetch.md
# pipe_fetch

Instruction-fetch stage and IF/ID pipeline register of the five-stage pipelined CPU. It sits directly upstream of the decode stage. It owns the PC, drives a variable-latency instruction-memory handshake, and presents `inst`/`dpc4` to decode. It consumes decode's `pcsource`, `bpc`, `rpc`, `jpc` and `nostall`, and implements the one-instruction branch delay slot. A one-entry skid buffer absorbs a fetch response that returns while decode is stalled.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address (= `pc`)
- `imem_ack`  in  1  request complete; `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched instruction
- `pcsource`  in  2  next-PC select for the instruction in IF/ID: 00 pc+4, 01 `bpc`, 10 `rpc`, 11 `jpc`
- `bpc`, `rpc`, `jpc`  in  32 each  branch, register (jr) and jump targets from decode
- `nostall`  in  1  decode accepts the IF/ID instruction this cycle
- `inst`  out  32  IF/ID instruction; 32'h0 (nop) when empty
- `dpc4`  out  32  IF/ID instruction's PC+4
- `dvalid`  out  1  IF/ID holds a real instruction
- `pc`  out  32  next address to fetch (debug)

## Operation
- State: `pc`, IF/ID register (`inst`, `dpc4`, `dvalid`), skid register (`sinst`, `spc4`, `svalid`), pending redirect (`pend`, `ptgt`).
- Reset values: `pc`=RESET_PC; `inst`=0; `dpc4`=0; `dvalid`=0; `svalid`=0; `pend`=0; `ptgt`=0.
- `imem_req` = !`svalid` & !`rst`. `imem_addr` = `pc`.
- Invariant: at most one instruction younger than IF/ID exists, either in the skid register or as the outstanding request. This makes the younger instruction always the delay slot of a branch held in IF/ID.
- `consume` = `dvalid` & `nostall`. `ack` = `imem_req` & `imem_ack`.
- IF/ID load happens when `dvalid`=0 or `consume`:
  - if `svalid`, load from skid and clear `svalid`;
  - else if `ack`, load `imem_rdata` with `dpc4`=`pc`+4;
  - else clear `dvalid` and set `inst`=0; `dpc4` holds.
- When IF/ID is occupied and not consumed, an `ack` writes the skid register: `sinst`=`imem_rdata`, `spc4`=`pc`+4, `svalid`=1.
- PC update on `ack`: `pc` <= `pend` ? `ptgt` : `pc`+4; `pend` clears.
- Redirect occurs when `consume` & `pcsource`≠00. The target is selected by `pcsource`.
  - If the delay slot is already fetched (`svalid`, or `ack` this cycle), `pc` <= target. This overrides pc+4 in the same-cycle case.
  - Otherwise the delay-slot request is still outstanding: `pend` <= 1, `ptgt` <= target, and `pc` is unchanged.
- A redirect while `pend`=1 (branch in a delay slot, illegal MIPS) overwrites `ptgt`. No other defined behaviour.
- Arithmetic: pc+4 is a 32-bit add and wraps at 2^32. The low two bits of `pc` are not forced.

## Timing
- `imem_req`/`imem_addr` are combinational from registers (Moore). They are stable from request rise until `ack`. Memory may ack in the same cycle `imem_req` rises (zero wait).
- Fetch-to-decode latency: an instruction acked in cycle N is on `inst` in cycle N+1.
- With zero-wait memory and `nostall`=1, throughput is one instruction per cycle.
- While `svalid`=1, `imem_req`=0. The request re-asserts the cycle after the skid register drains.
- `rst` asserted mid-transaction drops `imem_req` immediately. Memory must abandon the transaction. The first request after release is RESET_PC.

## Test plan
- **Reset, zero-wait, `nostall`=1, `pcsource`=00:** addresses 0,4,8,C on consecutive cycles. `inst` = word@0 one cycle after the first ack, `dpc4`=4. `dvalid` stays high.
- **Ack delayed 3 cycles:** `imem_req`=1 and `imem_addr`=4 are held for all 4 cycles. `dvalid`=0 and `inst`=0 during the gap.
- **`nostall`=0 for 3 cycles with IF/ID holding 0x10:** the 0x14 ack fills the skid; `imem_req`=0. On release, 0x14 enters IF/ID, and the next cycle requests 0x18.
- **beq at 0x10, `pcsource`=01, `bpc`=0x40, delay slot acked the same cycle:** fetch order is 0x10, 0x14, 0x40. `dpc4` sequence is 0x14, 0x18, 0x44.
- **jr at 0x20, `rpc`=0x80, delay slot 0x24 outstanding (ack 2 cycles late):** `pend`=1 and `imem_addr` stays 0x24. After the ack, `pc`=0x80 and `pend`=0. 0x28 is never requested.
- **`rst` pulsed while a request is outstanding:** all outputs return to reset values asynchronously. After release, the first request is RESET_PC.
